// File: rtl/mlp_seq_engine.sv
// Time-multiplexed two-layer fixed-point MLP: one signed MAC, an FSM,
// a run-time weight memory and valid/ready handshakes on both sides.
module mlp_seq_engine #(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_BITS    = 12,
    parameter int NUM_FEATURES = 2,
    parameter int NUM_HIDDEN   = 8,
    parameter int THRESHOLD    = 1 << (FRAC_BITS - 1),
    parameter int NUM_WEIGHTS  =
        NUM_HIDDEN * (NUM_FEATURES + 1) + NUM_HIDDEN + 1,
    parameter int WADDR_WIDTH  =
        (NUM_WEIGHTS > 2) ? $clog2(NUM_WEIGHTS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_FEATURES*DATA_WIDTH-1:0] in_data,
    input  logic                               wr_en,
    input  logic [WADDR_WIDTH-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              out_score,
    output logic                               out_class,
    output logic                               busy
);

    localparam int MAXT    = (NUM_FEATURES > NUM_HIDDEN) ?
                             NUM_FEATURES : NUM_HIDDEN;
    localparam int PW      = 2 * DATA_WIDTH;
    localparam int AW      = PW + $clog2(MAXT + 2);
    localparam int TW      = $clog2(MAXT + 1);
    localparam int HW      = (NUM_HIDDEN > 1) ? $clog2(NUM_HIDDEN) : 1;
    localparam int L2_BASE = NUM_HIDDEN * (NUM_FEATURES + 1);

    localparam logic signed [DATA_WIDTH-1:0] ONE =
        DATA_WIDTH'(1 << FRAC_BITS);
    localparam logic signed [DATA_WIDTH-1:0] THR =
        DATA_WIDTH'(THRESHOLD);

    typedef enum logic [2:0] {
        IDLE,
        L1_MAC,
        L1_WB,
        L2_MAC,
        L2_WB,
        DONE
    } state_t;

    state_t                        state_q, state_d;
    logic signed [AW-1:0]          acc_q, acc_d;
    logic [TW-1:0]                 term_q, term_d;
    logic [HW-1:0]                 h_q, h_d;
    logic signed [DATA_WIDTH-1:0]  feat_q [NUM_FEATURES];
    logic signed [DATA_WIDTH-1:0]  feat_d [NUM_FEATURES];
    logic signed [DATA_WIDTH-1:0]  hid_q  [NUM_HIDDEN];
    logic signed [DATA_WIDTH-1:0]  hid_d  [NUM_HIDDEN];
    logic signed [DATA_WIDTH-1:0]  score_q, score_d;
    logic                          class_q, class_d;

    logic signed [DATA_WIDTH-1:0]  w_mem [NUM_WEIGHTS];

    logic [WADDR_WIDTH-1:0]        raddr;
    logic [TW-1:0]                 tm1;
    logic signed [DATA_WIDTH-1:0]  wdat;
    logic signed [DATA_WIDTH-1:0]  opnd;
    logic signed [PW-1:0]          prod;
    logic signed [DATA_WIDTH-1:0]  rq;

    // Floor shift, then clamp when the upper bits are not a pure sign run.
    function automatic logic signed [DATA_WIDTH-1:0] requant(
        input logic signed [AW-1:0] a
    );
        logic signed [AW-1:0] s;
        s = a >>> FRAC_BITS;
        if (!s[AW-1] && (|s[AW-2:DATA_WIDTH-1]))
            requant = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (s[AW-1] && !(&s[AW-2:DATA_WIDTH-1]))
            requant = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            requant = s[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        raddr = '0;
        opnd  = ONE;
        tm1   = term_q - TW'(1);
        if (state_q == L2_MAC) begin
            raddr = WADDR_WIDTH'(L2_BASE + int'(term_q));
            if (term_q != '0)
                opnd = hid_q[tm1];
        end else begin
            raddr = WADDR_WIDTH'(int'(h_q) * (NUM_FEATURES + 1)
                                 + int'(term_q));
            if (term_q != '0)
                opnd = feat_q[tm1];
        end
    end

    assign wdat = w_mem[raddr];
    assign prod = PW'(wdat) * PW'(opnd);
    assign rq   = requant(acc_q);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        term_d  = term_q;
        h_d     = h_q;
        feat_d  = feat_q;
        hid_d   = hid_q;
        score_d = score_q;
        class_d = class_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < NUM_FEATURES; i++)
                        feat_d[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                    state_d = L1_MAC;
                    acc_d   = '0;
                    term_d  = '0;
                    h_d     = '0;
                end
            end
            L1_MAC: begin
                acc_d = acc_q + AW'(prod);
                if (term_q == TW'(NUM_FEATURES)) begin
                    term_d  = '0;
                    state_d = L1_WB;
                end else begin
                    term_d = term_q + TW'(1);
                end
            end
            L1_WB: begin
                hid_d[h_q] = rq[DATA_WIDTH-1] ? '0 : rq;
                acc_d      = '0;
                if (h_q == HW'(NUM_HIDDEN - 1)) begin
                    state_d = L2_MAC;
                end else begin
                    h_d     = h_q + HW'(1);
                    state_d = L1_MAC;
                end
            end
            L2_MAC: begin
                acc_d = acc_q + AW'(prod);
                if (term_q == TW'(NUM_HIDDEN)) begin
                    term_d  = '0;
                    state_d = L2_WB;
                end else begin
                    term_d = term_q + TW'(1);
                end
            end
            L2_WB: begin
                score_d = rq;
                class_d = (rq >= THR);
                acc_d   = '0;
                h_d     = '0;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            term_q  <= '0;
            h_q     <= '0;
            score_q <= '0;
            class_q <= 1'b0;
            for (int i = 0; i < NUM_FEATURES; i++)
                feat_q[i] <= '0;
            for (int i = 0; i < NUM_HIDDEN; i++)
                hid_q[i] <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            term_q  <= term_d;
            h_q     <= h_d;
            score_q <= score_d;
            class_q <= class_d;
            feat_q  <= feat_d;
            hid_q   <= hid_d;
        end
    end

    // Weights survive reset; writes land only while idle.
    always_ff @(posedge clk) begin
        if (!rst && state_q == IDLE && wr_en
            && int'(wr_addr) < NUM_WEIGHTS)
            w_mem[wr_addr] <= wr_data;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_score = score_q;
    assign out_class = class_q;

endmodule

// File: tb/tb_mlp_seq_engine.sv
// Bench for mlp_seq_engine: vector table plus hand-written sequences
// for backpressure, write lockout, write-on-accept and mid-run reset.
module tb_mlp_seq_engine;

    localparam int NW  = 33;
    localparam int L2B = 24;
    localparam int WAW = 6;
    localparam int LAT = 42;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              wr_en;
    logic [WAW-1:0]    wr_addr;
    logic [15:0]       wr_data;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_score;
    logic              out_class;
    logic              busy;

    mlp_seq_engine dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_score (out_score),
        .out_class (out_class),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          wset;
        logic [15:0] x0;
        logic [15:0] x1;
        logic [15:0] score;
        logic        cls;
    } vec_t;

    vec_t        tbl [10];
    logic [16:0] sbq [$];
    int          n_vec;
    int          n_bad;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = WAW'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic load(input int s);
        for (int a = 0; a < NW; a++)
            wr(a, 16'h0000);
        case (s)
            0: begin
                wr(1, 16'h1000);
                wr(L2B + 1, 16'h1000);
            end
            1: begin
                wr(1, 16'h1000);
                wr(3, 16'h0800);
                wr(5, 16'h1000);
                wr(21, 16'hF000);
                wr(22, 16'h2000);
                wr(L2B, 16'h0100);
                wr(L2B + 1, 16'h1000);
                wr(L2B + 2, 16'hF000);
                wr(L2B + 8, 16'h0800);
            end
            2: begin
                wr(1, 16'h7FFF);
                wr(L2B + 1, 16'h1000);
            end
            3: begin
                wr(1, 16'h1000);
                wr(L2B + 1, 16'h1000);
                wr(L2B, 16'h0400);
            end
            4: begin
                wr(1, 16'h1000);
                wr(L2B + 1, 16'hFFFF);
            end
            5: begin
                wr(1, 16'h7FFF);
                wr(L2B + 1, 16'h8000);
            end
            default: ;
        endcase
    endtask

    task automatic run(input string nm, input logic [15:0] x0,
                       input logic [15:0] x1, input logic [15:0] es,
                       input logic ec, input int hold,
                       input bit cwr, input logic [15:0] cwd);
        logic [16:0] e;
        int          cnt;
        chk({nm, " in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = {x1, x0};
        if (cwr) begin
            wr_en   = 1'b1;
            wr_addr = WAW'(1);
            wr_data = cwd;
        end
        sbq.push_back({ec, es});
        @(negedge clk);
        in_valid = 1'b0;
        wr_en    = 1'b0;
        chk({nm, " busy"}, 32'(busy), 32'd1);
        chk({nm, " in_ready_busy"}, 32'(in_ready), 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk({nm, " latency"}, 32'(cnt), 32'(LAT));
        e = sbq.pop_front();
        chk({nm, " score"}, 32'(out_score), 32'(e[15:0]));
        chk({nm, " class"}, 32'(out_class), 32'(e[16]));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            wr_en    = 1'b1;
            wr_addr  = WAW'(1);
            wr_data  = 16'h0000;
            @(negedge clk);
            chk({nm, " hold_valid"}, 32'(out_valid), 32'd1);
            chk({nm, " hold_score"}, 32'(out_score), 32'(e[15:0]));
            chk({nm, " hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        wr_en     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " valid_drop"}, 32'(out_valid), 32'd0);
        chk({nm, " back_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int cur;
        bit seen;
        n_vec = 0;
        n_bad = 0;
        tbl[0] = '{0, 16'h0800, 16'h0300, 16'h0800, 1'b1};
        tbl[1] = '{0, 16'h07FF, 16'h0000, 16'h07FF, 1'b0};
        tbl[2] = '{0, 16'hF800, 16'h0000, 16'h0000, 1'b0};
        tbl[3] = '{0, 16'h1234, 16'h7777, 16'h1234, 1'b1};
        tbl[4] = '{1, 16'h0C00, 16'h0400, 16'h0500, 1'b0};
        tbl[5] = '{1, 16'h0400, 16'h0C00, 16'hF100, 1'b0};
        tbl[6] = '{2, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b1};
        tbl[7] = '{3, 16'hF800, 16'h0000, 16'h0400, 1'b0};
        tbl[8] = '{4, 16'h0001, 16'h0000, 16'hFFFF, 1'b0};
        tbl[9] = '{5, 16'h7FFF, 16'h0000, 16'h8000, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst score", 32'(out_score), 32'd0);
        chk("rst class", 32'(out_class), 32'd0);

        cur = -1;
        foreach (tbl[i]) begin
            if (tbl[i].wset != cur) begin
                load(tbl[i].wset);
                cur = tbl[i].wset;
            end
            run($sformatf("vec%0d", i), tbl[i].x0, tbl[i].x1,
                tbl[i].score, tbl[i].cls, 0, 1'b0, 16'h0);
        end

        load(0);
        run("wr_accept", 16'h0800, 16'h0000, 16'h1000, 1'b1,
            0, 1'b1, 16'h2000);
        wr(1, 16'h1000);
        run("backpressure", 16'h0800, 16'h0300, 16'h0800, 1'b1,
            10, 1'b0, 16'h0);
        run("post_lockout", 16'h0800, 16'h0000, 16'h0800, 1'b1,
            0, 1'b0, 16'h0);

        in_valid = 1'b1;
        in_data  = {16'h0000, 16'h0800};
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst busy", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst no_result", 32'(seen), 32'd0);
        run("after_rst", 16'h0800, 16'h0000, 16'h0800, 1'b1,
            0, 1'b0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
